seven_segment_scanner: RTL



---
 rtl/seven_segment_scanner_pkg.sv | 19 +
 rtl/seven_segment_scanner_translator.sv | 38 +++
 rtl/seven_segment_scanner.sv | 128 ++++++++++++
 3 files changed

// File: rtl/seven_segment_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: slot states, nibble width
// and the segment "off" patterns for both board polarities.
package seven_segment_scanner_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } scan_state_t;

    localparam int NIBBLE_W = 4;

    localparam logic [6:0] SEG_OFF_ANODE   = 7'b1111111;
    localparam logic [6:0] SEG_OFF_CATHODE = 7'b0000000;

    function automatic logic [6:0] seg_off(input logic common_anod);
        return common_anod ? SEG_OFF_ANODE : SEG_OFF_CATHODE;
    endfunction

endpackage

// File: rtl/seven_segment_scanner_translator.sv
// Hex nibble to seven-segment decoder (bit 6 = g ... bit 0 = a), with the
// output polarity chosen by the board type.
module seven_segment_scanner_translator
    import seven_segment_scanner_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    input  logic                common_anod,
    output logic [6:0]          segment
);

    logic [6:0] seg_on;

    // Patterns are written active-high and inverted for common-anode boards.
    always_comb begin
        seg_on = 7'b0000000;
        case (nibble)
            4'h0: seg_on = 7'b0111111;
            4'h1: seg_on = 7'b0000110;
            4'h2: seg_on = 7'b1011011;
            4'h3: seg_on = 7'b1001111;
            4'h4: seg_on = 7'b1100110;
            4'h5: seg_on = 7'b1101101;
            4'h6: seg_on = 7'b1111101;
            4'h7: seg_on = 7'b0000111;
            4'h8: seg_on = 7'b1111111;
            4'h9: seg_on = 7'b1101111;
            4'hA: seg_on = 7'b1110111;
            4'hB: seg_on = 7'b1111100;
            4'hC: seg_on = 7'b0111001;
            4'hD: seg_on = 7'b1011110;
            4'hE: seg_on = 7'b1111001;
            4'hF: seg_on = 7'b1110001;
            default: seg_on = 7'b0000000;
        endcase
        segment = common_anod ? ~seg_on : seg_on;
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed seven-segment driver with blanking gaps and a frame-aligned
// double buffer. Define SEVEN_SEGMENT_SCANNER_LZB_EN for leading-zero blanking.
module seven_segment_scanner
    import seven_segment_scanner_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 16
) (
    input  logic                         i_CLK,
    input  logic                         i_RESET,
    input  logic [NIBBLE_W*DIGITS-1:0]   i_DATA,
    input  logic [DIGITS-1:0]            i_DP,
    input  logic                         i_LOAD,
    input  logic                         i_COMMON_ANOD,
    output logic [6:0]                   o_SEGMENT,
    output logic                         o_DP,
    output logic [DIGITS-1:0]            o_DIGIT_ENABLE,
    output logic                         o_FRAME_DONE
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = $clog2(DIGITS);

    logic [CNT_W-1:0]             cnt, cnt_nxt;
    logic [IDX_W-1:0]             idx, idx_nxt;
    scan_state_t                  state, state_nxt;
    logic [NIBBLE_W*DIGITS-1:0]   pending_data, display_data;
    logic [DIGITS-1:0]            pending_dp, display_dp;
    logic                         cnt_wrap, idx_wrap, frame_end, frame_done_nxt;
    logic [NIBBLE_W-1:0]          sel_nibble;
    logic                         sel_dp, sel_blank;
    logic [DIGITS-1:0]            lz_blank;
    logic [DIGITS-1:0]            onehot;
    logic [6:0]                   trans_seg;

    always_comb begin
        cnt_wrap       = (cnt == CNT_W'(PRESCALE - 1));
        idx_wrap       = (idx == IDX_W'(DIGITS - 1));
        frame_end      = cnt_wrap && idx_wrap;
        cnt_nxt        = cnt_wrap ? '0 : cnt + CNT_W'(1);
        idx_nxt        = cnt_wrap ? (idx_wrap ? '0 : idx + IDX_W'(1)) : idx;
        frame_done_nxt = (cnt_nxt == CNT_W'(PRESCALE - 1)) &&
                         (idx_nxt == IDX_W'(DIGITS - 1));
        state_nxt = state;
        case (state)
            S_BLANK: if (cnt_nxt == CNT_W'(BLANK)) state_nxt = S_SHOW;
            S_SHOW:  if (cnt_wrap)                 state_nxt = S_BLANK;
            default: state_nxt = S_BLANK;
        endcase
    end

    // A digit is blanked when it and every digit above it hold zero.
    always_comb begin
        lz_blank = '0;
`ifdef SEVEN_SEGMENT_SCANNER_LZB_EN
        begin
            logic seen;
            seen = 1'b0;
            for (int k = DIGITS - 1; k >= 1; k--) begin
                if (display_data[k*NIBBLE_W +: NIBBLE_W] != '0) seen = 1'b1;
                lz_blank[k] = !seen;
            end
        end
`endif
    end

    // Outputs are computed for the slot position being entered (idx_nxt).
    always_comb begin
        sel_nibble = '0;
        sel_dp     = 1'b0;
        sel_blank  = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_nxt == IDX_W'(k)) begin
                sel_nibble = display_data[k*NIBBLE_W +: NIBBLE_W];
                sel_dp     = display_dp[k];
                sel_blank  = lz_blank[k];
            end
        end
        onehot = {{(DIGITS-1){1'b0}}, 1'b1} << idx_nxt;
    end

    seven_segment_scanner_translator u_translator (
        .nibble      (sel_nibble),
        .common_anod (i_COMMON_ANOD),
        .segment     (trans_seg)
    );

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            cnt            <= '0;
            idx            <= '0;
            state          <= S_BLANK;
            pending_data   <= '0;
            pending_dp     <= '0;
            display_data   <= '0;
            display_dp     <= '0;
            o_SEGMENT      <= seg_off(i_COMMON_ANOD);
            o_DP           <= i_COMMON_ANOD;
            o_DIGIT_ENABLE <= {DIGITS{i_COMMON_ANOD}};
            o_FRAME_DONE   <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            idx          <= idx_nxt;
            state        <= state_nxt;
            o_FRAME_DONE <= frame_done_nxt;
            if (i_LOAD) begin
                pending_data <= i_DATA;
                pending_dp   <= i_DP;
            end
            // A load on the boundary cycle bypasses pending straight to display.
            if (frame_end) begin
                display_data <= i_LOAD ? i_DATA : pending_data;
                display_dp   <= i_LOAD ? i_DP   : pending_dp;
            end
            if (state_nxt == S_SHOW) begin
                o_SEGMENT      <= sel_blank ? seg_off(i_COMMON_ANOD) : trans_seg;
                o_DP           <= i_COMMON_ANOD ^ sel_dp;
                o_DIGIT_ENABLE <= i_COMMON_ANOD ? ~onehot : onehot;
            end else begin
                o_SEGMENT      <= seg_off(i_COMMON_ANOD);
                o_DP           <= i_COMMON_ANOD;
                o_DIGIT_ENABLE <= {DIGITS{i_COMMON_ANOD}};
            end
        end
    end

endmodule
